// File: rtl/tt_dco_pi_ctrl.sv
// PI frequency-locking controller for a digitally controlled oscillator: counts DCO edges over
// a fixed reference window and steers a saturating 32-bit delay control word.
module tt_dco_pi_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 256,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned KP_SHIFT      = 4,
  parameter int unsigned KI_SHIFT      = 1,
  parameter int unsigned LOCK_TOL      = 2,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int          CTRL_INIT     = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_dco_clk,
  input  logic        [15:0] i_target,
  output logic               o_dco_enable,
  output logic signed [31:0] o_control,
  output logic               o_control_valid,
  output logic signed [16:0] o_error,
  output logic               o_locked
);

  typedef enum logic [2:0] {StIdle, StSettle, StMeasure, StCalc, StUpdate} state_e;

  localparam int unsigned LockW = $clog2(LOCK_COUNT + 2);
  localparam logic signed [33:0] SatMax = 34'sd2147483647;
  localparam logic signed [33:0] SatMin = -34'sd2147483648;
  localparam logic signed [17:0] TolPos = 18'(LOCK_TOL);

  state_e             state;
  logic               dco_s1, dco_s2, dco_s3;
  logic               dco_rise;
  logic        [31:0] cyc_cnt;
  logic        [15:0] edge_cnt;
  logic        [15:0] edge_inc;
  logic signed [31:0] integ;
  logic   [LockW-1:0] lock_cnt;

  logic signed [16:0] calc_err;
  logic signed [17:0] err_wide;
  logic               in_tol;
  logic signed [33:0] err_w, integ_w, integ_sum, ctrl_sum, integ_next_w;
  logic signed [31:0] integ_next, ctrl_next;

  function automatic logic signed [31:0] sat32(input logic signed [33:0] v);
    logic signed [31:0] r;
    if (v > SatMax) begin
      r = 32'sh7FFF_FFFF;
    end else if (v < SatMin) begin
      r = 32'sh8000_0000;
    end else begin
      r = v[31:0];
    end
    return r;
  endfunction

  assign dco_rise = dco_s2 & ~dco_s3;
  assign edge_inc = (dco_rise && edge_cnt != 16'hFFFF) ? 16'(edge_cnt + 16'd1) : edge_cnt;
  assign calc_err = {1'b0, edge_cnt} - {1'b0, i_target};

  always_comb begin
    err_w        = {{17{o_error[16]}}, o_error};
    integ_w      = {{2{integ[31]}}, integ};
    integ_sum    = integ_w + (err_w <<< KI_SHIFT);
    integ_next   = sat32(integ_sum);
    integ_next_w = {{2{integ_next[31]}}, integ_next};
    ctrl_sum     = integ_next_w + (err_w <<< KP_SHIFT);
    ctrl_next    = sat32(ctrl_sum);
    err_wide     = {o_error[16], o_error};
    in_tol       = (err_wide <= TolPos) && (err_wide >= -TolPos);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state           <= StIdle;
      dco_s1          <= 1'b0;
      dco_s2          <= 1'b0;
      dco_s3          <= 1'b0;
      cyc_cnt         <= '0;
      edge_cnt        <= '0;
      lock_cnt        <= '0;
      integ           <= CTRL_INIT;
      o_control       <= CTRL_INIT;
      o_control_valid <= 1'b0;
      o_error         <= '0;
      o_locked        <= 1'b0;
      o_dco_enable    <= 1'b0;
    end else begin
      dco_s1          <= i_dco_clk;
      dco_s2          <= dco_s1;
      dco_s3          <= dco_s2;
      o_control_valid <= 1'b0;
      if (state != StIdle && !i_enable) begin
        // Drop out immediately; integrator and control word are kept for a warm restart.
        state        <= StIdle;
        o_dco_enable <= 1'b0;
        o_locked     <= 1'b0;
        lock_cnt     <= '0;
        cyc_cnt      <= '0;
        edge_cnt     <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            if (i_enable) begin
              state        <= StSettle;
              o_dco_enable <= 1'b1;
              cyc_cnt      <= '0;
            end
          end
          StSettle: begin
            if (cyc_cnt == 32'(SETTLE_CYCLES - 1)) begin
              state    <= StMeasure;
              cyc_cnt  <= '0;
              edge_cnt <= '0;
            end else begin
              cyc_cnt <= cyc_cnt + 32'd1;
            end
          end
          StMeasure: begin
            edge_cnt <= edge_inc;
            if (cyc_cnt == 32'(WINDOW_CYCLES - 1)) begin
              state   <= StCalc;
              cyc_cnt <= '0;
            end else begin
              cyc_cnt <= cyc_cnt + 32'd1;
            end
          end
          StCalc: begin
            o_error <= calc_err;
            state   <= StUpdate;
          end
          StUpdate: begin
            integ           <= integ_next;
            o_control       <= ctrl_next;
            o_control_valid <= 1'b1;
            state           <= StMeasure;
            edge_cnt        <= '0;
            if (in_tol) begin
              if (lock_cnt < LockW'(LOCK_COUNT)) lock_cnt <= lock_cnt + LockW'(1);
              if (lock_cnt >= LockW'(LOCK_COUNT - 1)) o_locked <= 1'b1;
            end else begin
              lock_cnt <= '0;
              o_locked <= 1'b0;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/tt_dco_pi_ctrl.md
TT_DCO_PI_CTRL -- requirements
Module: tt_dco_pi_ctrl

Interface
REQ-001 Parameter WINDOW_CYCLES, default 256: i_clk cycles per frequency-measurement window.
REQ-002 Parameter SETTLE_CYCLES, default 16: i_clk cycles waited after DCO enable before the first window.
REQ-003 Parameter KP_SHIFT, default 4: proportional gain, applied as error * 2^KP_SHIFT.
REQ-004 Parameter KI_SHIFT, default 1: integral gain, applied as error * 2^KI_SHIFT per update.
REQ-005 Parameter LOCK_TOL, default 2: max |error| counted as in-tolerance.
REQ-006 Parameter LOCK_COUNT, default 4: consecutive in-tolerance updates required to assert lock.
REQ-007 Parameter CTRL_INIT, default 0: reset/initial value of integrator and o_control.
REQ-008 i_clk  input  1  reference clock; the block's only clock.
REQ-009 i_rst_n  input  1  synchronous, active-low reset.
REQ-010 i_enable  input  1  loop enable; level-sensitive.
REQ-011 i_dco_clk  input  1  DCO output; asynchronous to i_clk.
REQ-012 i_target  input  16  required DCO rising-edge count per window.
REQ-013 o_dco_enable  output  1  drives the DCO enable.
REQ-014 o_control  output  32 signed  DCO delay control; larger value means slower DCO.
REQ-015 o_control_valid  output  1  one-cycle pulse when o_control updates.
REQ-016 o_error  output  17 signed  last computed error (count - target).
REQ-017 o_locked  output  1  loop lock indicator.

Function
REQ-018 i_dco_clk SHALL pass through a 2-flop synchronizer and a third flop for rising-edge detection; each detected rising edge counts once (valid for DCO frequency below f_clk/2).
REQ-019 FSM states: IDLE, SETTLE, MEASURE, CALC, UPDATE.
REQ-020 IDLE: o_dco_enable=0; on i_enable=1 go to SETTLE next cycle.
REQ-021 SETTLE: o_dco_enable=1; stay exactly SETTLE_CYCLES cycles, then MEASURE.
REQ-022 MEASURE: 16-bit edge counter cleared on entry, counts edges for exactly WINDOW_CYCLES cycles, saturates at 16'hFFFF; then CALC.
REQ-023 CALC (1 cycle): error = zero-extended count - zero-extended i_target in 17-bit signed; i_target is sampled only here; o_error updates here.
REQ-024 UPDATE (1 cycle): integ_next = sat32(integ + (error <<< KI_SHIFT)); o_control = sat32(integ_next + (error <<< KP_SHIFT)); o_control_valid=1 this cycle only; then MEASURE.
REQ-025 All intermediate sums SHALL be computed at 34 bits and saturated to [-2^31, 2^31-1]; no wrap-around.
REQ-026 Latency: o_control_valid asserts WINDOW_CYCLES+2 cycles after MEASURE entry; update period in steady state is WINDOW_CYCLES+2 cycles.
REQ-027 Lock: in UPDATE, if |error| <= LOCK_TOL increment a saturating in-tolerance counter, else clear it and deassert o_locked; o_locked=1 when counter reaches LOCK_COUNT.
REQ-028 i_enable=0 in any non-IDLE state: next cycle state=IDLE, o_dco_enable=0, o_locked=0, lock counter cleared, partial window discarded, no o_control_valid; integrator and o_control retained (warm restart).
REQ-029 i_enable re-asserted: restart from SETTLE using the retained integrator.
REQ-030 Edge detected in the same cycle as MEASURE entry SHALL be counted; edges in CALC/UPDATE are ignored.

Reset
REQ-031 i_rst_n=0 at a rising i_clk edge: state=IDLE, o_dco_enable=0, o_control=CTRL_INIT, integrator=CTRL_INIT, o_control_valid=0, o_error=0, o_locked=0, counters and synchronizer flops=0.
REQ-032 Reset SHALL take priority over i_enable and any in-progress window.

Verification
REQ-033 Defaults, i_target=64, DCO at f_clk/4 (64 edges/window) -> o_error=0, o_control stays 0, o_locked=1 after 4th o_control_valid.
REQ-034 i_target=64, DCO at f_clk/2.5 (~102 edges) -> first update o_error=+38 (+-1), o_control=38*16+38*2=684.
REQ-035 Integrator at 2^31-100, error=+100 -> o_control=2^31-1, no wrap.
REQ-036 i_enable dropped mid-MEASURE -> IDLE next cycle, o_dco_enable=0, no o_control_valid, o_control unchanged; re-enable -> SETTLE 16 cycles then MEASURE.
REQ-037 Locked loop, then one window with error=+3 -> o_locked=0 at that UPDATE, reasserts after 4 further in-tolerance updates.
REQ-038 Reset asserted during UPDATE -> next cycle all outputs at REQ-031 values.
